dds_wavegen_param: RTL and testbench

//  Parametrised DDS waveform generator, successor to the fixed 10-bit single-ROM generator.

---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_sine_qlut.sv | 57 +++++
 rtl/dds_wavegen_param.sv | 196 +++++++++++++++++++
 tb/tb_dds_wavegen_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: waveform codes, default widths
// and the sine table entry generator used by the quarter-wave ROM.
package dds_pkg;

    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_SQUARE = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SAW    = 2'b11;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_AMP_W   = 16;

    // Offset-binary sine sample k of a 2^addr_w point full period, rounded to nearest.
    function automatic int sine_lut_val(input int k, input int addr_w, input int out_w);
        real full_s;
        real ang_s;
        full_s = (2.0 ** out_w) - 1.0;
        ang_s  = 2.0 * 3.14159265358979 * real'(k) / (2.0 ** addr_w);
        return $rtoi(full_s / 2.0 * (1.0 + $sin(ang_s)) + 0.5);
    endfunction

endpackage

// File: rtl/dds_sine_qlut.sv
// Quarter-wave sine ROM with address mirroring and value inversion to cover the full
// period; one registered stage of latency.
module dds_sine_qlut
    import dds_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [OUT_W-1:0]  data_o
);
    localparam int Q_W = ADDR_W - 2;
    localparam int Q_N = 1 << Q_W;

    logic [OUT_W-1:0] rom_s [Q_N];
    logic [Q_W-1:0]   q_s;
    logic [Q_W-1:0]   idx_s;
    logic             peak_s;
    logic [OUT_W-1:0] mag_s;
    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;

    for (genvar k = 0; k < Q_N; k++) begin : g_rom
        assign rom_s[k] = OUT_W'(sine_lut_val(k, ADDR_W, OUT_W));
    end

    assign q_s = addr_i[Q_W-1:0];

    // Mirrored quarters read entry 2^Q_W - q; q = 0 there is the crest, which the table lacks.
    always_comb begin
        idx_s  = q_s;
        peak_s = 1'b0;
        if (addr_i[ADDR_W-2]) begin
            idx_s  = ~q_s + {{(Q_W-1){1'b0}}, 1'b1};
            peak_s = (q_s == {Q_W{1'b0}});
        end else begin
            idx_s  = q_s;
            peak_s = 1'b0;
        end
        mag_s  = peak_s ? {OUT_W{1'b1}} : rom_s[idx_s];
        data_d = addr_i[ADDR_W-1] ? ~mag_s : mag_s;
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {OUT_W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_wavegen_param.sv
// Parametrised DDS generator: phase accumulator, immediate or wrap-synchronous
// reconfiguration, and a 3-stage waveform / amplitude pipeline.
module dds_wavegen_param
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic               cfg_sync,
    input  logic [1:0]         cfg_wave,
    input  logic [PHASE_W-1:0] cfg_fword,
    input  logic [PHASE_W-1:0] cfg_pword,
    input  logic [AMP_W-1:0]   cfg_aword,
    output logic               cfg_busy,
    output logic               phase_wrap,
    output logic               dout_valid,
    output logic [OUT_W-1:0]   dout
);
    localparam int PH_KEEP = (OUT_W + 1 > ADDR_W) ? OUT_W + 1 : ADDR_W;

    logic [PHASE_W-1:0] acc_q, acc_sum_s;
    logic               carry_s, wrap_now_s, wrap_q;
    logic [PHASE_W-1:0] fword_q, fword_d, pword_q, pword_d;
    logic [PHASE_W-1:0] sh_fword_q, sh_fword_d, sh_pword_q, sh_pword_d;
    logic [1:0]         wave_q, wave_d, sh_wave_q, sh_wave_d;
    logic [AMP_W-1:0]   aword_q, aword_d, sh_aword_q, sh_aword_d;
    logic               busy_q, busy_d;

    logic [PH_KEEP-1:0]         ph_top_s, ph_s1_q;
    logic [PHASE_W-PH_KEEP-1:0] ph_low_unused_s;
    logic                       valid_s1_q, valid_s2_q, dout_valid_q;
    logic [1:0]                 wave_s1_q, wave_s2_q;
    logic [AMP_W-1:0]           aword_s1_q, aword_s2_q;
    logic [OUT_W-1:0]           raw_s1_s, raw_s2_q, sine_s2_s, raw_sel_s, dout_d, dout_q;
    logic [AMP_W:0]             amp_s;
    logic [AMP_W-1:0]           prod_frac_unused_s;

    assign {carry_s, acc_sum_s} = {1'b0, acc_q} + {1'b0, fword_q};
    assign wrap_now_s           = en & carry_s;

    // A sync load landing on a wrap takes effect at once, so it never sits in the shadow.
    always_comb begin
        fword_d    = fword_q;
        pword_d    = pword_q;
        wave_d     = wave_q;
        aword_d    = aword_q;
        sh_fword_d = sh_fword_q;
        sh_pword_d = sh_pword_q;
        sh_wave_d  = sh_wave_q;
        sh_aword_d = sh_aword_q;
        busy_d     = busy_q;
        if (cfg_load && (!cfg_sync || wrap_now_s)) begin
            fword_d = cfg_fword;
            pword_d = cfg_pword;
            wave_d  = cfg_wave;
            aword_d = cfg_aword;
            busy_d  = 1'b0;
        end else if (cfg_load) begin
            sh_fword_d = cfg_fword;
            sh_pword_d = cfg_pword;
            sh_wave_d  = cfg_wave;
            sh_aword_d = cfg_aword;
            busy_d     = 1'b1;
        end else if (busy_q && wrap_now_s) begin
            fword_d = sh_fword_q;
            pword_d = sh_pword_q;
            wave_d  = sh_wave_q;
            aword_d = sh_aword_q;
            busy_d  = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Accumulator, wrap strobe, active and shadow configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= {PHASE_W{1'b0}};
            wrap_q     <= 1'b0;
            fword_q    <= {PHASE_W{1'b0}};
            pword_q    <= {PHASE_W{1'b0}};
            wave_q     <= WAVE_SINE;
            aword_q    <= {AMP_W{1'b1}};
            sh_fword_q <= {PHASE_W{1'b0}};
            sh_pword_q <= {PHASE_W{1'b0}};
            sh_wave_q  <= WAVE_SINE;
            sh_aword_q <= {AMP_W{1'b1}};
            busy_q     <= 1'b0;
        end else begin
            acc_q      <= en ? acc_sum_s : acc_q;
            wrap_q     <= wrap_now_s;
            fword_q    <= fword_d;
            pword_q    <= pword_d;
            wave_q     <= wave_d;
            aword_q    <= aword_d;
            sh_fword_q <= sh_fword_d;
            sh_pword_q <= sh_pword_d;
            sh_wave_q  <= sh_wave_d;
            sh_aword_q <= sh_aword_d;
            busy_q     <= busy_d;
        end
    end

    assign {ph_top_s, ph_low_unused_s} = acc_q + pword_q;

    // S1: phase sample with the settings that produced it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_q <= 1'b0;
            ph_s1_q    <= {PH_KEEP{1'b0}};
            wave_s1_q  <= WAVE_SINE;
            aword_s1_q <= {AMP_W{1'b0}};
        end else begin
            valid_s1_q <= en;
            if (en) begin
                ph_s1_q    <= ph_top_s;
                wave_s1_q  <= wave_q;
                aword_s1_q <= aword_q;
            end else begin
                ph_s1_q    <= ph_s1_q;
                wave_s1_q  <= wave_s1_q;
                aword_s1_q <= aword_s1_q;
            end
        end
    end

    always_comb begin
        raw_s1_s = {OUT_W{1'b0}};
        case (wave_s1_q)
            WAVE_SQUARE: raw_s1_s = ph_s1_q[PH_KEEP-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
            WAVE_TRI:    raw_s1_s = ph_s1_q[PH_KEEP-1] ? ~ph_s1_q[PH_KEEP-2 -: OUT_W]
                                                       : ph_s1_q[PH_KEEP-2 -: OUT_W];
            WAVE_SAW:    raw_s1_s = ph_s1_q[PH_KEEP-1 -: OUT_W];
            default:     raw_s1_s = {OUT_W{1'b0}};
        endcase
    end

    dds_sine_qlut #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_sine (
        .clk    (clk),
        .rst    (rst),
        .addr_i (ph_s1_q[PH_KEEP-1 -: ADDR_W]),
        .data_o (sine_s2_s)
    );

    // S2: non-sine raw sample; the sine sample is registered inside the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s2_q <= 1'b0;
            raw_s2_q   <= {OUT_W{1'b0}};
            wave_s2_q  <= WAVE_SINE;
            aword_s2_q <= {AMP_W{1'b0}};
        end else begin
            valid_s2_q <= valid_s1_q;
            if (valid_s1_q) begin
                raw_s2_q   <= raw_s1_s;
                wave_s2_q  <= wave_s1_q;
                aword_s2_q <= aword_s1_q;
            end else begin
                raw_s2_q   <= raw_s2_q;
                wave_s2_q  <= wave_s2_q;
                aword_s2_q <= aword_s2_q;
            end
        end
    end

    // Scaling by aword+1 keeps aword = all-ones an exact pass-through.
    assign raw_sel_s = (wave_s2_q == WAVE_SINE) ? sine_s2_s : raw_s2_q;
    assign amp_s     = {1'b0, aword_s2_q} + {{AMP_W{1'b0}}, 1'b1};
    assign {dout_d, prod_frac_unused_s} = {{AMP_W{1'b0}}, raw_sel_s} * {{(OUT_W-1){1'b0}}, amp_s};

    // S3: output sample holds while no new sample arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_q       <= {OUT_W{1'b0}};
        end else begin
            dout_valid_q <= valid_s2_q;
            dout_q       <= valid_s2_q ? dout_d : dout_q;
        end
    end

    assign cfg_busy   = busy_q;
    assign phase_wrap = wrap_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_dds_wavegen_param.sv
// Scoreboard bench for dds_wavegen_param: stimulus queues expected samples, a monitor
// pops and compares them whenever dout_valid is high.
module tb_dds_wavegen_param;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, cfg_load, cfg_sync;
    logic [1:0]  cfg_wave;
    logic [31:0] cfg_fword, cfg_pword;
    logic [15:0] cfg_aword;
    logic        cfg_busy, phase_wrap, dout_valid;
    logic [15:0] dout;

    typedef struct {
        bit          chk;
        logic [15:0] val;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dds_wavegen_param #(
        .PHASE_W (32), .ADDR_W (10), .OUT_W (16), .AMP_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_sync   (cfg_sync),
        .cfg_wave   (cfg_wave),
        .cfg_fword  (cfg_fword),
        .cfg_pword  (cfg_pword),
        .cfg_aword  (cfg_aword),
        .cfg_busy   (cfg_busy),
        .phase_wrap (phase_wrap),
        .dout_valid (dout_valid),
        .dout       (dout)
    );

    // Monitor: every valid sample must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got %04h, none expected", dout);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) begin
                    n_tests++;
                    if (dout !== mon_e.val) begin
                        n_fail++;
                        $display("FAIL sample_%0d: got %04h expected %04h", mon_e.tag, dout, mon_e.val);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit chk, input logic [15:0] val, input int tag);
        en = 1'b1;
        exp_q.push_back('{chk, val, tag});
        tick();
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic [31:0] f, input logic [31:0] p,
                           input logic [15:0] a, input logic sync);
        cfg_load  = 1'b1;
        cfg_sync  = sync;
        cfg_wave  = w;
        cfg_fword = f;
        cfg_pword = p;
        cfg_aword = a;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        cfg_load = 1'b0;
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic start(input logic [1:0] w, input logic [31:0] f, input logic [31:0] p,
                         input logic [15:0] a);
        do_reset();
        set_cfg(w, f, p, a, 1'b0);
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        bit          c;
        logic [15:0] v;
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_sync = 1'b0;
        cfg_wave = 2'b00; cfg_fword = 32'h0; cfg_pword = 32'h0; cfg_aword = 16'h0;
        tick();
        tick();
        check("rst_dout", dout, 32'h0);
        check("rst_valid", dout_valid, 32'h0);
        check("rst_busy", cfg_busy, 32'h0);
        check("rst_wrap", phase_wrap, 32'h0);

        // Sawtooth at 2^24: 0x0100 per sample, wrap every 256 samples.
        start(WAVE_SAW, 32'h0100_0000, 32'h0, 16'hFFFF);
        for (int i = 0; i < 300; i++) begin
            issue(1'b1, 16'(i * 256), i);
            if (i == 1)   check("t1_valid_lat2", dout_valid, 32'h0);
            if (i == 2)   check("t1_valid_lat3", dout_valid, 32'h1);
            if (i == 254) check("t1_wrap_254", phase_wrap, 32'h0);
            if (i == 255) check("t1_wrap_255", phase_wrap, 32'h1);
            if (i == 256) check("t1_wrap_256", phase_wrap, 32'h0);
        end
        en = 1'b0;
        tick();
        check("t1_wrap_en_low", phase_wrap, 32'h0);
        tick();
        check("t1_valid_tail", dout_valid, 32'h1);
        tick();
        check("t1_valid_fall", dout_valid, 32'h0);
        check("t1_dout_hold", dout, 32'h2B00);

        // Square at half amplitude.
        start(WAVE_SQUARE, 32'h0100_0000, 32'h0, 16'h7FFF);
        for (int i = 0; i < 260; i++)
            issue(1'b1, ((i % 256) < 128) ? 16'h0000 : 16'h7FFF, 1000 + i);
        idle(4);

        // Triangle at fixed phase, then on-the-fly changes aligned to the samples.
        start(WAVE_TRI, 32'h0, 32'h4000_0000, 16'hFFFF);
        for (int i = 0; i < 6; i++) issue(1'b1, 16'h8000, 2000 + i);
        set_cfg(WAVE_TRI, 32'h0, 32'h8000_0000, 16'hFFFF, 1'b0);
        issue(1'b1, 16'h8000, 2006);
        cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b1, 16'hFFFF, 2007 + i);
        set_cfg(WAVE_SAW, 32'h0, 32'h4000_0000, 16'h7FFF, 1'b0);
        issue(1'b1, 16'hFFFF, 2012);
        cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b1, 16'h2000, 2013 + i);
        idle(4);

        // Sine at one LUT step per sample.
        start(WAVE_SINE, 32'h0040_0000, 32'h0, 16'hFFFF);
        for (int i = 0; i < 1100; i++) begin
            c = 1'b1;
            case (i)
                0:       v = 16'h8000;
                128:     v = 16'hDA82;
                256:     v = 16'hFFFF;
                384:     v = 16'hDA82;
                512:     v = 16'h7FFF;
                640:     v = 16'h257D;
                768:     v = 16'h0000;
                1024:    v = 16'h8000;
                default: begin c = 1'b0; v = 16'h0000; end
            endcase
            issue(c, v, 3000 + i);
        end
        idle(4);

        // Wrap-synchronous rate change from 2^24 to 2^25.
        start(WAVE_SINE, 32'h0100_0000, 32'h0, 16'hFFFF);
        for (int i = 0; i < 400; i++) begin
            if (i == 100) set_cfg(WAVE_SINE, 32'h0200_0000, 32'h0, 16'hFFFF, 1'b1);
            c = 1'b1;
            case (i)
                64:      v = 16'hFFFF;
                192:     v = 16'h0000;
                256:     v = 16'h8000;
                288:     v = 16'hFFFF;
                320:     v = 16'h7FFF;
                default: begin c = 1'b0; v = 16'h0000; end
            endcase
            issue(c, v, 4000 + i);
            cfg_load = 1'b0;
            if (i == 99)  check("t5_busy_before", cfg_busy, 32'h0);
            if (i == 100) check("t5_busy_set", cfg_busy, 32'h1);
            if (i == 254) check("t5_busy_254", cfg_busy, 32'h1);
            if (i == 254) check("t5_wrap_254", phase_wrap, 32'h0);
            if (i == 255) check("t5_wrap_255", phase_wrap, 32'h1);
            if (i == 255) check("t5_busy_clear", cfg_busy, 32'h0);
            if (i == 382) check("t5_wrap_382", phase_wrap, 32'h0);
            if (i == 383) check("t5_wrap_383", phase_wrap, 32'h1);
        end
        idle(4);

        // Reset mid-run with a pending update.
        start(WAVE_SAW, 32'h0100_0000, 32'h0, 16'hFFFF);
        for (int i = 0; i < 40; i++) issue(1'b1, 16'(i * 256), 5000 + i);
        set_cfg(WAVE_SAW, 32'h0200_0000, 32'h0, 16'hFFFF, 1'b1);
        issue(1'b1, 16'(40 * 256), 5040);
        cfg_load = 1'b0;
        check("t6_busy_pending", cfg_busy, 32'h1);
        for (int i = 0; i < 5; i++) issue(1'b1, 16'((41 + i) * 256), 5041 + i);
        rst = 1'b1;
        tick();
        check("t6_rst_dout", dout, 32'h0);
        check("t6_rst_valid", dout_valid, 32'h0);
        check("t6_rst_busy", cfg_busy, 32'h0);
        check("t6_rst_wrap", phase_wrap, 32'h0);
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) issue(1'b1, 16'h8000, 6000 + i);
        check("t6_busy_after", cfg_busy, 32'h0);
        idle(4);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
